// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants for the two-master Wishbone debug arbiter.
//               Holds the FSM state encodings, the master index constants
//               and the bit position of the halt flag in gdb_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_own_cpu = 2'd1;
    localparam logic [1:0] c_st_own_gdb = 2'd2;
    localparam logic [1:0] c_st_abort   = 2'd3;

    // Master indices
    localparam logic c_cpu = 1'b0;
    localparam logic c_gdb = 1'b1;

    // gdb_ctrl bit that reports "core halted, debug mode active"
    localparam int c_dbg_halt = 1;

    // One-hot grant vector for a master index
    function automatic logic [1:0] f_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Counts cycles of an unacknowledged strobe. Produces a
//               combinational expire pulse in the cycle where the count has
//               reached the limit while still enabled.
// Ports       : clk       - system clock
//               rst       - synchronous active-high reset
//               i_clr     - clear the count (ack seen or strobe low)
//               i_en      - count this cycle (strobe high, no ack)
//               i_limit   - expiry threshold
//               o_expire  - high when the enabled count equals the limit
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [TW-1:0] i_limit,
    output logic          o_expire
);

    logic [TW-1:0] r_cnt;
    logic          w_hit;

    assign w_hit    = (r_cnt == i_limit);
    // A clear in the same cycle (ack arrived) always suppresses expiry.
    assign o_expire = i_en & ~i_clr & w_hit;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_debug_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_debug_arbiter
// Description : Two-master Wishbone arbiter sharing one 16-bit slave port
//               between the CPU (master 0) and the GDB engine (master 1).
//               Round-robin on ties, GDB-only while the core is halted,
//               no preemption of an active cycle, and a timeout that aborts
//               hung cycles with a single-cycle error pulse.
// Ports       : clk_i, rst_i         - clock, synchronous active-high reset
//               gdb_ctrl_i[1:0]      - bit 1 = core halted / debug mode
//               m0_* / m1_*          - CPU / GDB master ports
//               wb_*                 - shared slave port
//               grant_o[1:0]         - registered one-hot current owner
// Revision    : 1.0 - initial release
// ============================================================================
module wb_debug_arbiter
    import wb_pkg::*;
#(
    parameter int            TW      = 8,
    parameter logic [TW-1:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  gdb_ctrl_i,
    // CPU master
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic [1:0]  m0_sel_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    // GDB master
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    input  logic [1:0]  m1_sel_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    // Slave port
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    output logic [1:0]  wb_sel_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    // Debug visibility
    output logic [1:0]  grant_o
);

    logic [1:0]  r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_last,  w_last_nxt;
    logic [1:0]  r_grant, w_grant_nxt;

    logic        w_owning;
    logic        w_own_cyc, w_own_stb, w_own_we;
    logic [31:0] w_own_adr;
    logic [15:0] w_own_dat;
    logic [1:0]  w_own_sel;
    logic        w_cnt_en;
    logic        w_expire;
    logic        w_halt;
    logic        w_unused_ctrl0;

    assign w_halt         = gdb_ctrl_i[c_dbg_halt];
    assign w_unused_ctrl0 = gdb_ctrl_i[0];

    // ------------------------------------------------------------------
    // Owner-side mux
    // ------------------------------------------------------------------
    assign w_owning  = (r_state == c_st_own_cpu) || (r_state == c_st_own_gdb);
    assign w_own_cyc = (r_owner == c_gdb) ? m1_cyc_i : m0_cyc_i;
    assign w_own_stb = (r_owner == c_gdb) ? m1_stb_i : m0_stb_i;
    assign w_own_we  = (r_owner == c_gdb) ? m1_we_i  : m0_we_i;
    assign w_own_adr = (r_owner == c_gdb) ? m1_adr_i : m0_adr_i;
    assign w_own_dat = (r_owner == c_gdb) ? m1_dat_i : m0_dat_i;
    assign w_own_sel = (r_owner == c_gdb) ? m1_sel_i : m0_sel_i;

    // IDLE and ABORT present a fully quiet slave bus.
    assign wb_cyc_o = w_owning & w_own_cyc;
    assign wb_stb_o = w_owning & w_own_stb;
    assign wb_we_o  = w_owning & w_own_we;
    assign wb_adr_o = w_owning ? w_own_adr : '0;
    assign wb_dat_o = w_owning ? w_own_dat : '0;
    assign wb_sel_o = w_owning ? w_own_sel : '0;

    assign m0_dat_o = w_owning ? wb_dat_i : '0;
    assign m1_dat_o = w_owning ? wb_dat_i : '0;

    assign m0_ack_o = w_owning & (r_owner == c_cpu) & wb_ack_i;
    assign m1_ack_o = w_owning & (r_owner == c_gdb) & wb_ack_i;
    assign m0_err_o = w_owning & (r_owner == c_cpu) & w_expire;
    assign m1_err_o = w_owning & (r_owner == c_gdb) & w_expire;

    assign grant_o  = r_grant;

    // ------------------------------------------------------------------
    // Timeout counter: runs only while the owner strobes without ack.
    // ------------------------------------------------------------------
    assign w_cnt_en = wb_stb_o & ~wb_ack_i;

    wb_timeout_counter #(
        .TW (TW)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_clr    (~w_cnt_en),
        .i_en     (w_cnt_en),
        .i_limit  (TIMEOUT),
        .o_expire (w_expire)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
            r_owner <= c_cpu;
            r_last  <= c_gdb;
            r_grant <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;

        case (r_state)
            c_st_idle: begin
                if (w_halt) begin
                    // Halted core: only the debugger may use the bus.
                    if (m1_cyc_i) begin
                        w_owner_nxt = c_gdb;
                    end
                end else if (m0_cyc_i && m1_cyc_i) begin
                    // Tie: whoever did not own the bus last time wins.
                    w_owner_nxt = (r_last == c_gdb) ? c_cpu : c_gdb;
                end else if (m0_cyc_i) begin
                    w_owner_nxt = c_cpu;
                end else if (m1_cyc_i) begin
                    w_owner_nxt = c_gdb;
                end

                if ((w_halt && m1_cyc_i) || (!w_halt && (m0_cyc_i || m1_cyc_i))) begin
                    w_state_nxt = (w_owner_nxt == c_gdb) ? c_st_own_gdb : c_st_own_cpu;
                    w_grant_nxt = f_onehot(w_owner_nxt);
                end
            end

            c_st_own_cpu, c_st_own_gdb: begin
                if (!w_own_cyc) begin
                    w_state_nxt = c_st_idle;
                    w_last_nxt  = r_owner;
                    w_grant_nxt = 2'b00;
                end else if (w_expire) begin
                    w_state_nxt = c_st_abort;
                end
            end

            c_st_abort: begin
                if (!w_own_cyc) begin
                    w_state_nxt = c_st_idle;
                    w_last_nxt  = r_owner;
                    w_grant_nxt = 2'b00;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_debug_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_debug_arbiter
// Description : Directed self-checking bench for wb_debug_arbiter
//               (TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_debug_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  gdb_ctrl_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i;
    logic [15:0] m0_dat_i;
    logic [1:0]  m0_sel_i;
    logic [15:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i;
    logic [15:0] m1_dat_i;
    logic [1:0]  m1_sel_i;
    logic [15:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;
    logic [1:0]  grant_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    wb_debug_arbiter #(
        .TW      (8),
        .TIMEOUT (8'd8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .gdb_ctrl_i (gdb_ctrl_i),
        .m0_cyc_i   (m0_cyc_i),
        .m0_stb_i   (m0_stb_i),
        .m0_we_i    (m0_we_i),
        .m0_adr_i   (m0_adr_i),
        .m0_dat_i   (m0_dat_i),
        .m0_sel_i   (m0_sel_i),
        .m0_dat_o   (m0_dat_o),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m1_cyc_i   (m1_cyc_i),
        .m1_stb_i   (m1_stb_i),
        .m1_we_i    (m1_we_i),
        .m1_adr_i   (m1_adr_i),
        .m1_dat_i   (m1_dat_i),
        .m1_sel_i   (m1_sel_i),
        .m1_dat_o   (m1_dat_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .grant_o    (grant_o)
    );

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic v);
        m0_cyc_i = v;
        m0_stb_i = v;
    endtask

    task automatic set_m1(input logic v);
        m1_cyc_i = v;
        m1_stb_i = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; gdb_ctrl_i = 2'b00;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = 16'h0C0C; m0_sel_i = 2'b11;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 32'h0000_2000; m1_dat_i = 16'h0D0D; m1_sel_i = 2'b11;
        wb_dat_i = 16'h1234; wb_ack_i = 0;

        // ---------------- reset state ----------------
        step(); step();
        rst_i = 1'b0;
        #1;
        chk("rst_grant",  grant_o,  2'b00);
        chk("rst_wb_cyc", wb_cyc_o, 1'b0);
        chk("rst_m0_dat", m0_dat_o, 16'h0000);
        chk("rst_m0_ack", m0_ack_o, 1'b0);

        // ---------------- CPU alone ----------------
        m0_adr_i = 32'h0000_1000;
        set_m0(1'b1);
        #1 chk("t1_idle_stb", wb_stb_o, 1'b0);
        step();
        chk("t1_grant",  grant_o,  2'b01);
        chk("t1_wb_stb", wb_stb_o, 1'b1);
        chk("t1_wb_adr", wb_adr_o, 32'h0000_1000);
        step(); step();
        wb_ack_i = 1'b1; wb_dat_i = 16'hBEEF;
        #1;
        chk("t1_m0_ack", m0_ack_o, 1'b1);
        chk("t1_m0_dat", m0_dat_o, 16'hBEEF);
        chk("t1_m1_ack", m1_ack_o, 1'b0);
        step();
        wb_ack_i = 1'b0;
        set_m0(1'b0);
        step();
        chk("t1_release", grant_o, 2'b00);

        // ---------------- round robin from reset ----------------
        rst_i = 1'b1; step(); rst_i = 1'b0;
        set_m0(1'b1); set_m1(1'b1);
        for (int r = 0; r < 8; r++) begin
            step();
            chk("rr_grant", grant_o, (r % 2 == 0) ? 2'b01 : 2'b10);
            wb_ack_i = 1'b1;
            #1;
            chk("rr_owner_ack", (r % 2 == 0) ? m0_ack_o : m1_ack_o, 1'b1);
            chk("rr_other_ack", (r % 2 == 0) ? m1_ack_o : m0_ack_o, 1'b0);
            step();
            wb_ack_i = 1'b0;
            if (r % 2 == 0) set_m0(1'b0); else set_m1(1'b0);
            step();
            chk("rr_idle_grant", grant_o, 2'b00);
            chk("rr_idle_cyc", wb_cyc_o, 1'b0);
            if (r % 2 == 0) set_m0(1'b1); else set_m1(1'b1);
        end
        set_m0(1'b0); set_m1(1'b0);
        step();

        // ---------------- debug lockout ----------------
        gdb_ctrl_i = 2'b10;
        set_m0(1'b1); set_m1(1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lock_grant", grant_o, 2'b10);
            wb_ack_i = 1'b1;
            #1;
            chk("lock_m1_ack", m1_ack_o, 1'b1);
            chk("lock_m0_ack", m0_ack_o, 1'b0);
            step();
            wb_ack_i = 1'b0;
            set_m1(1'b0);
            step();
            chk("lock_idle", grant_o, 2'b00);
            if (i < 4) set_m1(1'b1);
        end
        gdb_ctrl_i = 2'b00;
        step();
        chk("lock_cpu_after", grant_o, 2'b01);
        set_m0(1'b0);
        step();

        // ---------------- no preemption ----------------
        set_m0(1'b1);
        step();
        chk("np_grant_cpu", grant_o, 2'b01);
        gdb_ctrl_i = 2'b10;
        set_m1(1'b1);
        for (int b = 0; b < 4; b++) begin
            wb_ack_i = 1'b1;
            wb_dat_i = 16'hA000 + 16'(b);
            #1;
            chk("np_beat_ack",   m0_ack_o, 1'b1);
            chk("np_beat_dat",   m0_dat_o, 16'hA000 + 16'(b));
            chk("np_beat_grant", grant_o,  2'b01);
            step();
        end
        wb_ack_i = 1'b0;
        set_m0(1'b0);
        step();
        chk("np_idle", grant_o, 2'b00);
        step();
        chk("np_grant_gdb", grant_o, 2'b10);
        set_m1(1'b0);
        gdb_ctrl_i = 2'b00;
        step();

        // ---------------- timeout, never acked ----------------
        set_m1(1'b1);
        step();
        for (int k = 1; k <= 8; k++) begin
            chk("to_no_err", m1_err_o, 1'b0);
            step();
        end
        chk("to_err_pulse", m1_err_o, 1'b1);
        chk("to_m0_err",    m0_err_o, 1'b0);
        chk("to_cyc_live",  wb_cyc_o, 1'b1);
        step();
        chk("to_err_once",  m1_err_o, 1'b0);
        chk("to_abort_cyc", wb_cyc_o, 1'b0);
        chk("to_abort_stb", wb_stb_o, 1'b0);
        step();
        chk("to_abort_hold", wb_cyc_o, 1'b0);
        set_m1(1'b0);
        step();
        chk("to_idle", grant_o, 2'b00);

        // ---------------- ack on stb cycle 8 ----------------
        set_m1(1'b1);
        step();
        for (int k = 1; k <= 7; k++) begin
            chk("a8_no_err", m1_err_o, 1'b0);
            step();
        end
        wb_ack_i = 1'b1;
        #1;
        chk("a8_ack", m1_ack_o, 1'b1);
        chk("a8_err", m1_err_o, 1'b0);
        step();
        wb_ack_i = 1'b0;
        #1;
        chk("a8_cleared_err", m1_err_o, 1'b0);
        chk("a8_grant",       grant_o,  2'b10);
        set_m1(1'b0);
        step();

        // ---------------- ack coincides with expiry ----------------
        set_m1(1'b1);
        step();
        for (int k = 1; k <= 8; k++) step();
        wb_ack_i = 1'b1;
        #1;
        chk("a9_ack", m1_ack_o, 1'b1);
        chk("a9_err", m1_err_o, 1'b0);
        step();
        wb_ack_i = 1'b0;
        #1;
        chk("a9_no_abort", wb_cyc_o, 1'b1);
        set_m1(1'b0);
        step();

        // ---------------- reset mid-cycle ----------------
        set_m0(1'b1);
        step();
        chk("rm_cpu", grant_o, 2'b01);
        set_m0(1'b0);
        step();
        set_m1(1'b1);
        step();
        chk("rm_gdb",     grant_o,  2'b10);
        chk("rm_gdb_stb", wb_stb_o, 1'b1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        wb_ack_i = 1'b1;
        #1;
        chk("rm_grant",  grant_o,  2'b00);
        chk("rm_cyc",    wb_cyc_o, 1'b0);
        chk("rm_stb",    wb_stb_o, 1'b0);
        chk("rm_adr",    wb_adr_o, 32'h0);
        chk("rm_m1_ack", m1_ack_o, 1'b0);
        chk("rm_m1_dat", m1_dat_o, 16'h0);
        wb_ack_i = 1'b0;
        set_m0(1'b1);
        step();
        chk("rm_tie_cpu", grant_o, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_debug_arbiter.md
# wb_debug_arbiter

Two-master Wishbone arbiter that shares the 16-bit target bus between the moxie CPU (master 0) and the GDB target engine (master 1). It sits between both masters and the single memory/peripheral slave port. It decides ownership per bus cycle, gives the debugger exclusive access while the core is halted, and terminates hung cycles with an error after a timeout.

## Interface
Parameters:
- TIMEOUT, 8'd255, cycles of unacknowledged `stb` before the arbiter aborts the cycle.
- TW, 8, width of the timeout counter.

Ports (reset is synchronous and active-high):
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- gdb_ctrl_i  in  2  debug control from the GDB engine. Bit 1 set means the core is halted and in debug mode.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  CPU master controls
- m0_adr_i  in  32  CPU address
- m0_dat_i  in  16  CPU write data
- m0_sel_i  in  2  CPU byte selects
- m0_dat_o  out  16  read data to CPU
- m0_ack_o, m0_err_o  out  1 each  CPU terminations
- m1_* (same set and widths as m0_*)  GDB engine master
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  slave-side controls
- wb_adr_o  out  32  slave-side address
- wb_dat_o  out  16  slave-side write data
- wb_sel_o  out  2  slave-side byte selects
- wb_dat_i  in  16  slave read data
- wb_ack_i  in  1  slave acknowledge
- grant_o  out  2  one-hot current owner (debug visibility)

## Operation
- FSM states: IDLE, OWN_CPU, OWN_GDB, ABORT.
- IDLE: no master is granted, and every slave-side output is 0.
  - Requests are m0_cyc_i and m1_cyc_i.
  - If gdb_ctrl_i[1]=1, only m1 can be granted.
  - Otherwise, when both masters request, the one not granted last wins (round robin via `last` register, reset value `last`=GDB, so the CPU wins the first tie).
  - A single requester wins outright.
- OWN_x:
  - Slave-side cyc/stb/we/adr/dat/sel are muxed combinationally from master x.
  - wb_dat_i is routed to both m*_dat_o.
  - Only the owner sees wb_ack_i on its ack output. The non-owner's ack and err are held at 0.
  - Ownership persists across consecutive stb phases while m_x cyc stays high (block transfers are not split).
  - On the cycle the owner drops cyc: go to IDLE and update `last`.
- Debug entry (gdb_ctrl_i[1] rising while in OWN_CPU): no preemption. The CPU cycle completes, then m1 gets priority from IDLE.
- Timeout:
  - The counter clears on every cycle where wb_ack_i=1 or stb is low, and increments while the owner's stb=1 and ack=0.
  - When the count reaches TIMEOUT, the owner receives m_x_err_o=1 for exactly one cycle and the FSM enters ABORT.
  - ACK and expiry in the same cycle: ack wins, there is no error, and the counter clears.
- ABORT:
  - Slave-side cyc/stb are forced to 0.
  - The FSM waits for the owner to drop cyc, then goes to IDLE with `last` updated.
- Reset, including mid-cycle:
  - Every output goes to 0 and grant_o=2'b00.
  - FSM goes to IDLE, the counter goes to 0, and `last`=GDB.
  - Any in-flight slave cycle is dropped.

## Timing
- Grant latency: a request in IDLE at edge N produces ownership and slave-side stb visible after edge N+1.
  - A request sampled on edge N is visible on the slave bus in cycle N+1.
  - ack in the same cycle as the slave's ack: combinational pass-through, zero added latency.
- Release: one dead IDLE cycle between owners, always, even when the same master re-requests.
- m_x_dat_o is valid whenever m_x_ack_o=1.
- err: a single-cycle pulse on the expiry edge. Its earliest possible position is cycle TIMEOUT+1 of the stb phase.
- grant_o and state are registered. Slave-side outputs are combinational from the registered state and the owner's inputs.

## Structure
- A shared package (`wb_pkg`) holds:
  - state encodings
  - the master index constants CPU=0 and GDB=1
  - the debug bit index in gdb_ctrl (DBG_HALT=1)
- One natural sub-module, `wb_timeout_counter`:
  - inputs: TW-bit counter, clear, enable, limit
  - output: expire pulse
- The mux and FSM stay in the top level.

## Test plan
- CPU alone: m0 reads adr 32'h0000_1000, slave acks 2 cycles after stb with wb_dat_i=16'hBEEF -> m0_dat_o=16'hBEEF with m0_ack_o, grant_o=2'b01, m1_ack_o stays 0.
- Simultaneous requests from reset: both cyc rise together, gdb_ctrl_i=0 -> CPU granted first. When it releases, there is 1 idle cycle, then GDB is granted. Repeat for 4 rounds, expecting strict alternation.
- Debug lockout: gdb_ctrl_i=2'b10 with both requesting -> GDB is granted every time across 5 back-to-back cycles, and the CPU is never granted until gdb_ctrl_i[1]=0.
- No preemption: gdb_ctrl_i[1] rises during a 4-beat CPU burst -> all 4 CPU acks are delivered, then grant_o=2'b10 after one idle cycle.
- Timeout: TIMEOUT=8, slave never acks -> m1_err_o pulses once on the 9th stb cycle, wb_cyc_o=0 in ABORT, and the FSM returns to IDLE after m1 drops cyc. Also drive ack on exactly cycle 8 -> ack with no err.
- Reset mid-cycle: assert rst_i while OWN_GDB with stb high -> next cycle all outputs are 0, grant_o=2'b00, and a later simultaneous request grants the CPU.
